// File: rtl/mmram_merge_arbiter.sv
// rtl/mmram_merge_arbiter.sv - two-channel round-robin merge arbiter for 4-phase bundled-data links
// Async Send/Ack inputs are synchronised; one packet forwarded per full handshake.
module mmram_merge_arbiter #(
  parameter int DW          = 32,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16,
  parameter int TIMEOUT     = 255
) (
  input  logic             CLK,
  input  logic             MR,
  input  logic             Send_a,
  input  logic [DW-1:0]    Data_a,
  output logic             Ack_a,
  input  logic             Send_b,
  input  logic [DW-1:0]    Data_b,
  output logic             Ack_b,
  output logic             Send_out,
  output logic [DW-1:0]    Data_out,
  input  logic             Ack_in,
  output logic             grant_b,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic             err
);

  typedef enum logic [1:0] {IDLE = 2'd0, FWD = 2'd1, RET = 2'd2} state_t;

  localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT);

  state_t                 state_q;
  logic [SYNC_STAGES-1:0] sync_a_q, sync_b_q, sync_k_q;
  logic                   send_out_q, ack_a_q, ack_b_q, grant_b_q, err_q;
  logic [DW-1:0]          data_out_q;
  logic [CNT_W-1:0]       pkt_cnt_q;
  logic [15:0]            tmo_q;
  logic                   sa, sb, ak, pick_d, s_pick;

  always_ff @(posedge CLK) begin
    if (MR) begin
      sync_a_q <= '0;
      sync_b_q <= '0;
      sync_k_q <= '0;
    end else begin
      sync_a_q[0] <= Send_a;
      sync_b_q[0] <= Send_b;
      sync_k_q[0] <= Ack_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_a_q[i] <= sync_a_q[i-1];
        sync_b_q[i] <= sync_b_q[i-1];
        sync_k_q[i] <= sync_k_q[i-1];
      end
    end
  end

  assign sa = sync_a_q[SYNC_STAGES-1];
  assign sb = sync_b_q[SYNC_STAGES-1];
  assign ak = sync_k_q[SYNC_STAGES-1];

  // On a tie the channel that did not own the last transfer wins.
  assign pick_d = (sa && sb) ? ~grant_b_q : sb;
  assign s_pick = grant_b_q ? sb : sa;

  always_ff @(posedge CLK) begin
    if (MR) begin
      state_q    <= IDLE;
      send_out_q <= 1'b0;
      ack_a_q    <= 1'b0;
      ack_b_q    <= 1'b0;
      data_out_q <= '0;
      grant_b_q  <= 1'b1;
      pkt_cnt_q  <= '0;
      err_q      <= 1'b0;
      tmo_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (sa || sb) begin
            grant_b_q  <= pick_d;
            data_out_q <= pick_d ? Data_b : Data_a;
            send_out_q <= 1'b1;
            tmo_q      <= '0;
            state_q    <= FWD;
          end
        end
        FWD: begin
          if (ak) begin
            send_out_q <= 1'b0;
            ack_a_q    <= ~grant_b_q;
            ack_b_q    <= grant_b_q;
            state_q    <= RET;
          end else if (tmo_q != TMO_LIMIT) begin
            // Timeout only flags; the handshake is still allowed to finish.
            tmo_q <= tmo_q + 16'd1;
            if (tmo_q == TMO_LIMIT - 16'd1) begin
              err_q <= 1'b1;
            end
          end
        end
        RET: begin
          if (!s_pick && !ak) begin
            ack_a_q   <= 1'b0;
            ack_b_q   <= 1'b0;
            pkt_cnt_q <= pkt_cnt_q + CNT_W'(1);
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Send_out = send_out_q;
  assign Data_out = data_out_q;
  assign Ack_a    = ack_a_q;
  assign Ack_b    = ack_b_q;
  assign grant_b  = grant_b_q;
  assign pkt_cnt  = pkt_cnt_q;
  assign err      = err_q;

endmodule

// File: tb/tb_mmram_merge_arbiter.sv
// tb/tb_mmram_merge_arbiter.sv - scoreboard bench for mmram_merge_arbiter
module tb_mmram_merge_arbiter;

  logic        CLK = 1'b0;
  logic        MR, Send_a, Send_b, Ack_in;
  logic [31:0] Data_a, Data_b;
  logic        Ack_a, Ack_b, Send_out, grant_b, err;
  logic [31:0] Data_out;
  logic [3:0]  pkt_cnt;

  mmram_merge_arbiter #(.DW(32), .SYNC_STAGES(2), .CNT_W(4), .TIMEOUT(8)) dut (
    .CLK(CLK), .MR(MR),
    .Send_a(Send_a), .Data_a(Data_a), .Ack_a(Ack_a),
    .Send_b(Send_b), .Data_b(Data_b), .Ack_b(Ack_b),
    .Send_out(Send_out), .Data_out(Data_out), .Ack_in(Ack_in),
    .grant_b(grant_b), .pkt_cnt(pkt_cnt), .err(err)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {logic ch; logic [31:0] data;} exp_t;
  exp_t sb_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int ack_both = 0;
  int gap_viol = 0;
  int resp_en  = 0;
  int ack_delay = 2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic wait_send_out(input logic lvl, input string tag);
    for (int i = 0; i < 300 && Send_out !== lvl; i++) @(negedge CLK);
    check(tag, 32'(Send_out), 32'(lvl));
  endtask

  task automatic wait_ack(input logic ch, input logic lvl);
    for (int i = 0; i < 300 && (ch ? Ack_b : Ack_a) !== lvl; i++) @(negedge CLK);
    check($sformatf("ack_%s_%0d", ch ? "b" : "a", lvl), 32'(ch ? Ack_b : Ack_a), 32'(lvl));
  endtask

  task automatic send_pkt(input logic ch, input logic [31:0] d);
    @(negedge CLK);
    if (ch) begin Data_b = d; Send_b = 1'b1; end
    else    begin Data_a = d; Send_a = 1'b1; end
    wait_ack(ch, 1'b1);
    if (ch) Send_b = 1'b0; else Send_a = 1'b0;
    wait_ack(ch, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    MR = 1'b1; Send_a = 1'b0; Send_b = 1'b0; Ack_in = 1'b0;
    repeat (2) @(negedge CLK);
    MR = 1'b0;
  endtask

  // Downstream stage model: acks ack_delay cycles after Send_out, releases after it drops.
  initial forever begin
    @(negedge CLK);
    if (resp_en != 0 && Send_out && !Ack_in) begin
      repeat (ack_delay) @(negedge CLK);
      Ack_in = 1'b1;
      for (int i = 0; i < 400 && Send_out; i++) @(negedge CLK);
      Ack_in = 1'b0;
    end
  end

  // Output monitor: every new Send_out pops one expected grant/data pair.
  initial begin
    logic so_prev;
    int   low_run;
    exp_t e;
    so_prev = 1'b0;
    low_run = 2;
    forever begin
      @(negedge CLK);
      if (Send_out && !so_prev) begin
        if (low_run < 2) gap_viol++;
        if (sb_q.size() == 0) check("sb_underflow", 32'(sb_q.size()), 1);
        else begin
          e = sb_q.pop_front();
          check("grant", 32'(grant_b), 32'(e.ch));
          check("data", Data_out, e.data);
        end
      end
      low_run = Send_out ? 0 : low_run + 1;
      so_prev = Send_out;
      if (Ack_a && Ack_b) ack_both++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n;
    MR = 1'b1; Send_a = 1'b0; Send_b = 1'b0; Ack_in = 1'b0;
    Data_a = '0; Data_b = '0;
    repeat (3) @(negedge CLK);
    check("rst_send_out", 32'(Send_out), 0);
    check("rst_ack_a", 32'(Ack_a), 0);
    check("rst_ack_b", 32'(Ack_b), 0);
    check("rst_data_out", Data_out, 0);
    check("rst_grant_b", 32'(grant_b), 1);
    check("rst_pkt_cnt", 32'(pkt_cnt), 0);
    check("rst_err", 32'(err), 0);
    MR = 1'b0;

    // single A packet with latency measurement
    sb_q.push_back('{1'b0, 32'hDEADBEEF});
    @(negedge CLK);
    Data_a = 32'hDEADBEEF; Send_a = 1'b1;
    n = 0;
    do begin @(posedge CLK); #1; n++; end while (!Send_out && n < 20);
    check("t1_send_lat", n, 3);
    repeat (3) @(negedge CLK);
    Ack_in = 1'b1;
    n = 0;
    do begin @(posedge CLK); #1; n++; end while (!Ack_a && n < 20);
    check("t1_ack_lat", n, 3);
    check("t1_send_drop", 32'(Send_out), 0);
    @(negedge CLK);
    Send_a = 1'b0; Ack_in = 1'b0;
    wait_ack(1'b0, 1'b0);
    check("t1_pkt_cnt", 32'(pkt_cnt), 1);
    check("t1_grant_b", 32'(grant_b), 0);
    check("t1_data_hold", Data_out, 32'hDEADBEEF);

    // simultaneous requests, four packets each, alternate A/B
    do_reset();
    resp_en = 1; ack_delay = 2;
    for (int i = 0; i < 4; i++) begin
      sb_q.push_back('{1'b0, 32'hA000_0000 + 32'(i)});
      sb_q.push_back('{1'b1, 32'hB000_0000 + 32'(i)});
    end
    fork
      for (int i = 0; i < 4; i++) send_pkt(1'b0, 32'hA000_0000 + 32'(i));
      for (int i = 0; i < 4; i++) send_pkt(1'b1, 32'hB000_0000 + 32'(i));
    join
    check("t2_pkt_cnt", 32'(pkt_cnt), 8);

    // B arrives during A's FWD, A re-requests at once: B goes first
    do_reset();
    ack_delay = 3;
    sb_q.push_back('{1'b0, 32'h1111_0001});
    sb_q.push_back('{1'b1, 32'h2222_0002});
    sb_q.push_back('{1'b0, 32'h1111_0003});
    fork
      begin send_pkt(1'b0, 32'h1111_0001); send_pkt(1'b0, 32'h1111_0003); end
      begin wait_send_out(1'b1, "t3_fwd"); send_pkt(1'b1, 32'h2222_0002); end
    join
    check("t3_pkt_cnt", 32'(pkt_cnt), 3);
    resp_en = 0;

    // timeout: err after 8 FWD cycles, handshake still completes
    do_reset();
    sb_q.push_back('{1'b1, 32'h7777_0004});
    fork
      send_pkt(1'b1, 32'h7777_0004);
      begin
        wait_send_out(1'b1, "t4_fwd");
        repeat (7) @(negedge CLK);
        check("t4_err_before", 32'(err), 0);
        @(negedge CLK);
        check("t4_err_set", 32'(err), 1);
        check("t4_send_held", 32'(Send_out), 1);
        repeat (5) @(negedge CLK);
        Ack_in = 1'b1;
        wait_send_out(1'b0, "t4_send_drop");
        Ack_in = 1'b0;
      end
    join
    check("t4_pkt_cnt", 32'(pkt_cnt), 1);
    check("t4_err_sticky", 32'(err), 1);
    do_reset();
    check("t4_err_cleared", 32'(err), 0);

    // MR while in RET, then held Send_a is granted again
    sb_q.push_back('{1'b0, 32'h5555_AAAA});
    sb_q.push_back('{1'b0, 32'h5555_AAAA});
    @(negedge CLK);
    Data_a = 32'h5555_AAAA; Send_a = 1'b1;
    wait_send_out(1'b1, "t5_fwd");
    @(negedge CLK);
    Ack_in = 1'b1;
    wait_ack(1'b0, 1'b1);
    MR = 1'b1; Ack_in = 1'b0;
    @(negedge CLK);
    MR = 1'b0;
    check("t5_ack_a", 32'(Ack_a), 0);
    check("t5_send_out", 32'(Send_out), 0);
    check("t5_data_out", Data_out, 0);
    check("t5_pkt_cnt", 32'(pkt_cnt), 0);
    check("t5_grant_b", 32'(grant_b), 1);
    wait_send_out(1'b1, "t5_regrant");
    @(negedge CLK);
    Ack_in = 1'b1;
    wait_ack(1'b0, 1'b1);
    Send_a = 1'b0; Ack_in = 1'b0;
    wait_ack(1'b0, 1'b0);
    check("t5_pkt_cnt_after", 32'(pkt_cnt), 1);

    // 17 transfers wrap the 4-bit counter
    do_reset();
    resp_en = 1; ack_delay = 1;
    for (int i = 0; i < 17; i++) begin
      logic [31:0] d;
      logic        ch;
      d  = $urandom;
      ch = 1'($urandom_range(0, 1));
      sb_q.push_back('{ch, d});
      send_pkt(ch, d);
    end
    check("t6_pkt_wrap", 32'(pkt_cnt), 1);
    resp_en = 0;

    repeat (4) @(negedge CLK);
    check("ack_exclusive", ack_both, 0);
    check("send_gap", gap_viol, 0);
    check("sb_empty", 32'(sb_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
